// File: rtl/pwm_meas_if.sv
// rtl/pwm_meas_if.sv - enable, PWM input and measurement results of pwm_meas
interface pwm_meas_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] h_time;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_lvl;

  modport master (
    output en, pwm_in,
    input  period, h_time, meas_valid, timeout, stuck_lvl
  );

  modport slave (
    input  en, pwm_in,
    output period, h_time, meas_valid, timeout, stuck_lvl
  );
endinterface

// File: rtl/pwm_meas.sv
// rtl/pwm_meas.sv - PWM period / high-time meter with no-edge timeout
module pwm_meas #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic      clk,
  input  logic      reset,
  pwm_meas_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic             sync_a, sync_b, sync_d;
  logic             rise, fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] h_lat, h_lat_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] h_time_q, h_time_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;
  logic             stuck_q, stuck_nxt;
  logic [CNT_W-1:0] cnt_inc, tmr_inc;
  logic             tmr_hit, to_evt;

  // Two-flop synchronizer, delay flop, then a registered edge strobe.
  // sync_d is the level that matches the strobe the FSM is looking at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_a <= bus.pwm_in;
      sync_b <= sync_a;
      sync_d <= sync_b;
      rise   <= sync_b & ~sync_d;
      fall   <= ~sync_b & sync_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tmr       <= '0;
      h_lat     <= '0;
      period_q  <= '0;
      h_time_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tmr       <= tmr_nxt;
      h_lat     <= h_lat_nxt;
      period_q  <= period_nxt;
      h_time_q  <= h_time_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
      stuck_q   <= stuck_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tmr_nxt     = tmr;
    h_lat_nxt   = h_lat;
    period_nxt  = period_q;
    h_time_nxt  = h_time_q;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout_q;
    stuck_nxt   = stuck_q;
    to_evt      = 1'b0;
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    tmr_inc     = tmr + CNT_ONE;
    tmr_hit     = (tmr_inc == TMO);

    if (!bus.en) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      tmr_nxt     = '0;
      timeout_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_RISE;
          cnt_nxt   = '0;
          tmr_nxt   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_nxt = HIGH;
            cnt_nxt   = CNT_ONE;
            tmr_nxt   = '0;
          end else if (tmr_hit) begin
            to_evt = 1'b1;
          end else begin
            tmr_nxt = tmr_inc;
          end
        end
        HIGH: begin
          if (fall) begin
            state_nxt = LOW;
            h_lat_nxt = cnt;
            cnt_nxt   = cnt_inc;
            tmr_nxt   = '0;
          end else if (tmr_hit) begin
            to_evt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
            tmr_nxt = tmr_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_nxt   = HIGH;
            period_nxt  = cnt;
            h_time_nxt  = h_lat;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b0;
            cnt_nxt     = CNT_ONE;
            tmr_nxt     = '0;
          end else if (tmr_hit) begin
            to_evt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
            tmr_nxt = tmr_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // Only the first timeout after a good period is reported; later ones
      // just track the stuck level until a full period clears the flag.
      if (to_evt) begin
        if (!timeout_q) begin
          valid_nxt  = 1'b1;
          period_nxt = '0;
          h_time_nxt = sync_d ? CNT_MAX : '0;
        end
        timeout_nxt = 1'b1;
        stuck_nxt   = sync_d;
        state_nxt   = WAIT_RISE;
        cnt_nxt     = '0;
        tmr_nxt     = '0;
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.h_time     = h_time_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.stuck_lvl  = stuck_q;
endmodule

// File: tb/tb_pwm_meas.sv
// tb/tb_pwm_meas.sv - pwm_meas (16-bit and 4-bit builds) against a timestamp reference model
module tb_pwm_meas;
  localparam int W0 = 16;
  localparam int T0 = 1000;
  localparam int W1 = 4;
  localparam int T1 = 15;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic en     = 1'b0;
  logic pwm_in = 1'b0;

  int checks = 0;
  int errors = 0;

  pwm_meas_if #(.CNT_W(W0)) b0 ();
  pwm_meas_if #(.CNT_W(W1)) b1 ();

  assign b0.en     = en;
  assign b0.pwm_in = pwm_in;
  assign b1.en     = en;
  assign b1.pwm_in = pwm_in;

  pwm_meas #(.CNT_W(W0), .TIMEOUT(T0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  pwm_meas #(.CNT_W(W1), .TIMEOUT(T1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: works on the cycle index of edges as the meter sees them
  // (input sample delayed three clocks), with periods as timestamp differences.
  int  maxv [2] = '{(1 << W0) - 1, (1 << W1) - 1};
  int  tmo  [2] = '{T0, T1};
  bit  active [2];
  bit  armed  [2];
  int  t_rise [2];
  int  h_hi   [2];
  int  t_ref  [2];
  int  e_per  [2];
  int  e_h    [2];
  bit  e_val  [2];
  bit  e_to   [2];
  bit  e_stuck[2];
  bit  hist[$];
  int  cyc = 0;
  bit  lv, pv;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; armed[i] = 0; t_rise[i] = 0; h_hi[i] = -1; t_ref[i] = 0;
      e_per[i] = 0; e_h[i] = 0; e_val[i] = 0; e_to[i] = 0; e_stuck[i] = 0;
    end
    hist = '{1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_step(input int i, input bit l, input bit p);
    e_val[i] = 0;
    if (!en) begin
      active[i] = 0;
      e_to[i]   = 0;
      return;
    end
    if (!active[i]) begin
      active[i] = 1;
      armed[i]  = 0;
      t_ref[i]  = cyc;
      return;
    end
    if (l && !p) begin
      if (armed[i] && h_hi[i] >= 0) begin
        e_per[i] = sat(cyc - t_rise[i], maxv[i]);
        e_h[i]   = sat(h_hi[i], maxv[i]);
        e_val[i] = 1;
        e_to[i]  = 0;
      end
      armed[i] = 1; t_rise[i] = cyc; h_hi[i] = -1; t_ref[i] = cyc;
    end else if (!l && p && armed[i]) begin
      h_hi[i]  = cyc - t_rise[i];
      t_ref[i] = cyc;
    end else if (cyc - t_ref[i] == tmo[i]) begin
      if (!e_to[i]) begin
        e_val[i] = 1;
        e_per[i] = 0;
        e_h[i]   = l ? maxv[i] : 0;
      end
      e_to[i] = 1; e_stuck[i] = l; armed[i] = 0; t_ref[i] = cyc;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        model_reset();
      end else begin
        lv = hist[1];
        pv = hist[0];
        model_step(0, lv, pv);
        model_step(1, lv, pv);
        hist.push_back(pwm_in);
        void'(hist.pop_front());
      end
      @(negedge clk);
      if (reset) model_reset();
      check("out16", 64'({b0.period, b0.h_time, b0.meas_valid, b0.timeout, b0.stuck_lvl}),
            64'({e_per[0][W0-1:0], e_h[0][W0-1:0], e_val[0], e_to[0], e_stuck[0]}));
      check("out4", 64'({b1.period, b1.h_time, b1.meas_valid, b1.timeout, b1.stuck_lvl}),
            64'({e_per[1][W1-1:0], e_h[1][W1-1:0], e_val[1], e_to[1], e_stuck[1]}));
    end
  end

  task automatic hold(input logic l, input int n);
    pwm_in = l;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pwm(input int p, input int h, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  int p, h;

  initial begin
    @(negedge clk);
    check("rst16", 64'({b0.period, b0.h_time, b0.meas_valid, b0.timeout, b0.stuck_lvl}), 64'(0));
    check("rst4", 64'({b1.period, b1.h_time, b1.meas_valid, b1.timeout, b1.stuck_lvl}), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    en = 1'b1;
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 7);
    pwm_in = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("latency", 64'(b0.meas_valid), 64'(j == 4));
    end
    @(posedge clk);
    #2;
    hold(1'b0, 4);
    pwm(10, 3, 20);
    check("p10", 64'(b0.period), 64'(10));
    check("h3", 64'(b0.h_time), 64'(3));
    check("to_clear", 64'(b0.timeout), 64'(0));

    hold(1'b0, 1200);
    check("stuck_to", 64'(b0.timeout), 64'(1));
    check("stuck_lvl0", 64'(b0.stuck_lvl), 64'(0));
    check("stuck_per", 64'({b0.period, b0.h_time}), 64'(0));
    pwm(10, 3, 2);
    check("to_recover", 64'(b0.timeout), 64'(0));
    check("recover_p", 64'(b0.period), 64'(10));

    hold(1'b1, 2);
    en = 1'b0;
    hold(1'b1, 2);
    en = 1'b1;
    hold(1'b1, 1);
    hold(1'b0, 5);
    pwm(10, 4, 5);
    check("en_drop_h", 64'(b0.h_time), 64'(4));

    hold(1'b1, 3);
    hold(1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid", 64'({b0.period, b0.h_time, b0.meas_valid, b0.timeout, b0.stuck_lvl}), 64'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    pwm(10, 3, 5);
    check("rst_rec", 64'(b0.h_time), 64'(3));

    for (int d = 0; d <= 10; d++) begin
      if (d == 0 || d == 10) begin
        hold(d == 10, 1100);
        check("duty_to", 64'(b0.timeout), 64'(1));
        check("duty_lvl", 64'(b0.stuck_lvl), 64'(d == 10));
      end else begin
        pwm(10, d, 50);
        check("duty_h", 64'(b0.h_time), 64'(d));
      end
    end
    check("hi_htime", 64'(b0.h_time), 64'(16'hffff));

    pwm(20, 10, 6);
    check("sat_p", 64'(b1.period), 64'(15));
    check("sat_h", 64'(b1.h_time), 64'(10));
    pwm(20, 3, 4);
    check("sat_to", 64'(b1.timeout), 64'(1));
    check("sat_per0", 64'(b1.period), 64'(0));

    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(30, 2);
      h = $urandom_range(p - 1, 1);
      if ($urandom_range(14, 0) == 0) begin
        en = 1'b0;
        hold(pwm_in, $urandom_range(4, 1));
        en = 1'b1;
      end
      pwm(p, h, 1);
    end
    for (int i = 0; i < 3; i++) begin
      hold(1'($urandom_range(1, 0)), $urandom_range(1100, 1000));
      pwm($urandom_range(30, 2), 1, 3);
    end
    hold(1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
